tra_safety_mon: RTL and testbench
=================================

// Module: tra_safety_mon
// PURPOSE
//  Downstream checker for the two tra signal heads (NS, EW). Samples both car/pedestrian light buses every
//  clock and flags unsafe combinations, illegal sequences, short yellows and stuck lights.
//  Captures the first fault and counts green phases per direction for the monitoring front-end.
// PARAMETERS
//  MIN_YELLOW  3     minimum consecutive cycles a car light must stay yellow before turning red
//  MAX_HOLD    1000  a car light unchanged for this many consecutive cycles is stuck
//  CNT_W       16    width of phase counters and internal dwell counters
// PORTS
//  clk           in   1      system clock, rising edge
//  rst_n         in   1      synchronous active-low reset
//  clr           in   1      sync fault clear; re-arms monitor
//  ns_car        in   2      NS car light: 00 red, 01 yellow, 10 green, 11 invalid
//  ns_hmn        in   2      NS pedestrian light, same encoding
//  ew_car        in   2      EW car light
//  ew_hmn        in   2      EW pedestrian light
//  fault         out  1      sticky fault flag
//  fault_code    out  3      code of first captured fault (0 = none)
//  ns_phase_cnt  out  CNT_W  count of NS car red->green transitions, saturating
//  ew_phase_cnt  out  CNT_W  count of EW car red->green transitions, saturating
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): fault=0, fault_code=0, both phase counts=0, dwell counters=0, state=ARM.
//  - FSM: ARM -> RUN after one cycle (loads prev_* registers from inputs; no checks in ARM).
//         RUN -> FAULT on any detected violation. FAULT -> ARM on clr. clr in RUN -> ARM (counts kept).
//  - Latency: a violation present on the inputs at edge N sets fault/fault_code at edge N (visible after N).
//  - Checks in RUN, compare inputs with prev_* (inputs sampled at previous edge):
//      1 any of the four buses = 11
//      2 ns_car and ew_car both non-red
//      3 pedestrian green against crossing car: ns_hmn=10 with ew_car!=00, or ew_hmn=10 with ns_car!=00
//      4 illegal car transition; legal: hold, R->G, G->Y, Y->R (so G->R, Y->G, R->Y are faults)
//      5 car Y->R after fewer than MIN_YELLOW consecutive yellow samples
//      6 car dwell counter reaches MAX_HOLD with light unchanged
//  - Several violations in one cycle: lowest code wins. Only the first fault is captured; later
//    violations in FAULT are ignored until clr.
//  - Dwell counter per direction: reset to 1 on car change, else increment, saturating at MAX_HOLD.
//  - Phase counters: +1 on each car R->G seen in RUN or FAULT; saturate at all-ones; cleared only by reset.
//  - clr and a new violation in the same cycle: clr wins, state=ARM, fault=0, fault_code=0.
//  - rst_n low mid-operation: everything returns to reset values at that edge, regardless of clr.
// CONFIGURATION
//  TRA_MON_FORCE_RED_EN defined: extra output force_red (1 bit), registered, =1 exactly while state=FAULT,
//    reset 0; drives the light controllers to all-red. Undefined: port and logic absent, checks unchanged.
// TESTING
//  - Reset then legal NS G(10)/Y(3)/R, EW mirrored, 150 cycles -> fault=0, ns_phase_cnt and ew_phase_cnt
//    increment once per R->G.
//  - Force ns_car=10 and ew_car=01 in the same cycle -> fault=1, fault_code=2 at that edge.
//  - NS car G->R directly -> fault_code=4; then clr=1 for one cycle -> fault=0, code=0, ARM then RUN.
//  - NS yellow held 2 cycles then red (MIN_YELLOW=3) -> fault_code=5; held 3 cycles -> no fault.
//  - Hold ew_car=10 unchanged with MAX_HOLD=20 -> fault_code=6 exactly when the dwell count hits 20.
//  - ns_car=11 and ew_hmn=10 with ns_car non-red in the same cycle -> fault_code=1 (priority);
//    with TRA_MON_FORCE_RED_EN defined, force_red=1 until clr.

Source files
------------

// File: rtl/tra_safety_mon.sv
// Safety monitor for the NS/EW signal heads: flags unsafe/illegal light behaviour, latches the first fault.
// Optional TRA_MON_FORCE_RED_EN adds a registered force_red output asserted while in FAULT.
module tra_safety_mon #(
   parameter int MIN_YELLOW = 3,
   parameter int MAX_HOLD   = 1000,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic [1:0]       ns_car,
   input  logic [1:0]       ns_hmn,
   input  logic [1:0]       ew_car,
   input  logic [1:0]       ew_hmn,
   output logic             fault,
   output logic [2:0]       fault_code,
   output logic [CNT_W-1:0] ns_phase_cnt,
   output logic [CNT_W-1:0] ew_phase_cnt
`ifdef TRA_MON_FORCE_RED_EN
   ,
   output logic             force_red
`endif
);

   localparam logic [1:0] ARM = 2'd0;
   localparam logic [1:0] RUN = 2'd1;
   localparam logic [1:0] FLT = 2'd2;

   localparam logic [1:0] RED = 2'b00;
   localparam logic [1:0] YEL = 2'b01;
   localparam logic [1:0] GRN = 2'b10;
   localparam logic [1:0] INV = 2'b11;

   localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
   localparam logic [CNT_W-1:0] YEL_MIN  = CNT_W'(MIN_YELLOW);
   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

   logic [1:0]       state, state_nxt;
   logic [1:0]       ns_prev, ew_prev;
   logic [CNT_W-1:0] ns_dwell, ew_dwell, ns_dwell_nxt, ew_dwell_nxt;
   logic             ns_chg, ew_chg;
   logic             v_inv, v_both, v_ped, v_trans, v_yel, v_hold;
   logic [2:0]       code_nxt;

   function automatic logic legal_step(input logic [1:0] p, input logic [1:0] c);
      return (p == c) || (p == RED && c == GRN) || (p == GRN && c == YEL) || (p == YEL && c == RED);
   endfunction

   assign ns_chg = (ns_car != ns_prev);
   assign ew_chg = (ew_car != ew_prev);
   assign ns_dwell_nxt = ns_chg ? ONE : ((ns_dwell == HOLD_MAX) ? ns_dwell : ns_dwell + ONE);
   assign ew_dwell_nxt = ew_chg ? ONE : ((ew_dwell == HOLD_MAX) ? ew_dwell : ew_dwell + ONE);

   assign v_inv   = (ns_car == INV) || (ns_hmn == INV) || (ew_car == INV) || (ew_hmn == INV);
   assign v_both  = (ns_car != RED) && (ew_car != RED);
   assign v_ped   = (ns_hmn == GRN && ew_car != RED) || (ew_hmn == GRN && ns_car != RED);
   assign v_trans = !legal_step(ns_prev, ns_car) || !legal_step(ew_prev, ew_car);
   // dwell still holds the yellow run length here, since it only resets after this edge
   assign v_yel   = (ns_prev == YEL && ns_car == RED && ns_dwell < YEL_MIN) ||
                    (ew_prev == YEL && ew_car == RED && ew_dwell < YEL_MIN);
   assign v_hold  = (!ns_chg && ns_dwell_nxt == HOLD_MAX) || (!ew_chg && ew_dwell_nxt == HOLD_MAX);

   always_comb begin
      code_nxt = 3'd0;
      if      (v_inv)   code_nxt = 3'd1;
      else if (v_both)  code_nxt = 3'd2;
      else if (v_ped)   code_nxt = 3'd3;
      else if (v_trans) code_nxt = 3'd4;
      else if (v_yel)   code_nxt = 3'd5;
      else if (v_hold)  code_nxt = 3'd6;
   end

   always_comb begin
      state_nxt = state;
      if (clr) state_nxt = ARM;
      else begin
         case (state)
            ARM:     state_nxt = RUN;
            RUN:     if (code_nxt != 3'd0) state_nxt = FLT;
            FLT:     state_nxt = FLT;
            default: state_nxt = ARM;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= ARM;
         ns_prev      <= RED;
         ew_prev      <= RED;
         ns_dwell     <= '0;
         ew_dwell     <= '0;
         ns_phase_cnt <= '0;
         ew_phase_cnt <= '0;
         fault        <= 1'b0;
         fault_code   <= 3'd0;
      end else begin
         state   <= state_nxt;
         ns_prev <= ns_car;
         ew_prev <= ew_car;
         if (state == ARM) begin
            ns_dwell <= ONE;
            ew_dwell <= ONE;
         end else begin
            ns_dwell <= ns_dwell_nxt;
            ew_dwell <= ew_dwell_nxt;
            if (ns_prev == RED && ns_car == GRN && ns_phase_cnt != '1) ns_phase_cnt <= ns_phase_cnt + ONE;
            if (ew_prev == RED && ew_car == GRN && ew_phase_cnt != '1) ew_phase_cnt <= ew_phase_cnt + ONE;
         end
         if (clr) begin
            fault      <= 1'b0;
            fault_code <= 3'd0;
         end else if (state == RUN && code_nxt != 3'd0) begin
            fault      <= 1'b1;
            fault_code <= code_nxt;
         end
      end
   end

`ifdef TRA_MON_FORCE_RED_EN
   always_ff @(posedge clk) begin
      if (!rst_n) force_red <= 1'b0;
      else        force_red <= (state_nxt == FLT);
   end
`endif

endmodule

// File: tb/tb_tra_safety_mon.sv
// Bench for tra_safety_mon: vector table, directed corner sequences and a randomized run vs a history-based model.
module tb_tra_safety_mon;
   localparam int MINY = 3;
   localparam int MAXH = 20;
   localparam int CW   = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0, clr = 1'b0;
   logic [1:0]    ns_car = '0, ns_hmn = '0, ew_car = '0, ew_hmn = '0;
   logic          fault;
   logic [2:0]    fault_code;
   logic [CW-1:0] ns_phase_cnt, ew_phase_cnt;
`ifdef TRA_MON_FORCE_RED_EN
   logic          force_red;
`endif

   tra_safety_mon #(.MIN_YELLOW(MINY), .MAX_HOLD(MAXH), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .ns_car(ns_car), .ns_hmn(ns_hmn), .ew_car(ew_car), .ew_hmn(ew_hmn),
      .fault(fault), .fault_code(fault_code),
      .ns_phase_cnt(ns_phase_cnt), .ew_phase_cnt(ew_phase_cnt)
`ifdef TRA_MON_FORCE_RED_EN
      , .force_red(force_red)
`endif
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model: state 0 arm / 1 run / 2 fault, car history since the last arm
   int m_st = 0, m_code = 0, m_cnt_ns = 0, m_cnt_ew = 0;
   int hn[$];
   int he[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int runlen(input int q[$]);
      int n = 0;
      for (int i = q.size() - 1; i >= 0; i--) begin
         if (q[i] != q[q.size()-1]) break;
         n++;
      end
      return n;
   endfunction

   function automatic bit legal(input int p, input int c);
      return (p == c) || (p == 0 && c == 2) || (p == 2 && c == 1) || (p == 1 && c == 0);
   endfunction

   task automatic model_step(input bit r, input bit c, input int nc, input int nh, input int ec, input int eh);
      int code = 0, pn = 0, pe = 0, rn = 0, re = 0;
      if (!r) begin
         m_st = 0; m_code = 0; m_cnt_ns = 0; m_cnt_ew = 0;
         hn.delete(); he.delete();
         return;
      end
      if (m_st != 0) begin
         pn = hn[$]; pe = he[$]; rn = runlen(hn); re = runlen(he);
      end
      if (m_st == 1) begin
         if (nc == 3 || nh == 3 || ec == 3 || eh == 3)                          code = 1;
         else if (nc != 0 && ec != 0)                                           code = 2;
         else if ((nh == 2 && ec != 0) || (eh == 2 && nc != 0))                 code = 3;
         else if (!legal(pn, nc) || !legal(pe, ec))                             code = 4;
         else if ((pn == 1 && nc == 0 && rn < MINY) || (pe == 1 && ec == 0 && re < MINY)) code = 5;
         else if ((nc == pn && rn + 1 == MAXH) || (ec == pe && re + 1 == MAXH)) code = 6;
      end
      if (m_st != 0) begin
         if (pn == 0 && nc == 2 && m_cnt_ns < 65535) m_cnt_ns++;
         if (pe == 0 && ec == 2 && m_cnt_ew < 65535) m_cnt_ew++;
      end
      if (m_st == 0) begin
         hn = {nc}; he = {ec};
      end else begin
         hn.push_back(nc); he.push_back(ec);
         if (hn.size() > MAXH + 2) void'(hn.pop_front());
         if (he.size() > MAXH + 2) void'(he.pop_front());
      end
      if (c)                          begin m_st = 0; m_code = 0; end
      else if (m_st == 0)             m_st = 1;
      else if (m_st == 1 && code != 0) begin m_st = 2; m_code = code; end
   endtask

   task automatic step(input logic r, input logic c, input logic [1:0] nc, input logic [1:0] nh,
                       input logic [1:0] ec, input logic [1:0] eh);
      rst_n = r; clr = c; ns_car = nc; ns_hmn = nh; ew_car = ec; ew_hmn = eh;
      @(posedge clk);
      #1;
      model_step(r, c, int'(nc), int'(nh), int'(ec), int'(eh));
   endtask

   function automatic logic [1:0] cycle_light(input int t);
      int m = t % 26;
      return (m < 10) ? 2'b10 : (m < 13) ? 2'b01 : 2'b00;
   endfunction

   function automatic logic [1:0] rnd_car(input logic [1:0] v, input logic [1:0] other);
      int k = $urandom_range(0, 99);
      if (k < 3)  return 2'($urandom_range(0, 3));
      if (k < 15 && !(v == 2'b00 && other != 2'b00))
         return (v == 2'b00) ? 2'b10 : (v == 2'b10) ? 2'b01 : 2'b00;
      return v;
   endfunction

   function automatic logic [1:0] rnd_hmn(input logic [1:0] own);
      int k = $urandom_range(0, 99);
      if (k < 80) return 2'b00;
      if (k < 96) return (own == 2'b10) ? 2'b10 : 2'b00;
      return 2'($urandom_range(0, 3));
   endfunction

   typedef struct {
      bit       r, c;
      bit [1:0] nc, nh, ec, eh;
      bit       f;
      int       code;
   } vec_t;

   vec_t tbl[16];

   initial begin
      int exp_ns, exp_ew;
      logic [1:0] pn, pe, nl, el, nc, ec;

      tbl[0]  = '{0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 0, 0};
      tbl[1]  = '{1, 0, 2'd0, 2'd0, 2'd0, 2'd0, 0, 0};
      tbl[2]  = '{1, 0, 2'd2, 2'd0, 2'd0, 2'd0, 0, 0};
      tbl[3]  = '{1, 0, 2'd2, 2'd0, 2'd1, 2'd0, 1, 2};
      tbl[4]  = '{1, 0, 2'd2, 2'd0, 2'd0, 2'd0, 1, 2};
      tbl[5]  = '{1, 1, 2'd2, 2'd0, 2'd0, 2'd0, 0, 0};
      tbl[6]  = '{1, 0, 2'd2, 2'd0, 2'd0, 2'd0, 0, 0};
      tbl[7]  = '{1, 0, 2'd0, 2'd0, 2'd0, 2'd0, 1, 4};
      tbl[8]  = '{1, 1, 2'd0, 2'd0, 2'd0, 2'd0, 0, 0};
      tbl[9]  = '{1, 0, 2'd0, 2'd0, 2'd0, 2'd0, 0, 0};
      tbl[10] = '{1, 0, 2'd3, 2'd0, 2'd0, 2'd2, 1, 1};
      tbl[11] = '{1, 1, 2'd0, 2'd0, 2'd0, 2'd0, 0, 0};
      tbl[12] = '{0, 0, 2'd3, 2'd0, 2'd0, 2'd0, 0, 0};
      tbl[13] = '{1, 0, 2'd0, 2'd0, 2'd0, 2'd0, 0, 0};
      tbl[14] = '{1, 0, 2'd0, 2'd2, 2'd2, 2'd0, 1, 3};
      tbl[15] = '{1, 1, 2'd0, 2'd0, 2'd3, 2'd0, 0, 0};

      @(negedge clk);
      for (int i = 0; i < 16; i++) begin
         step(tbl[i].r, tbl[i].c, tbl[i].nc, tbl[i].nh, tbl[i].ec, tbl[i].eh);
         chk($sformatf("vec%0d fault", i), fault, tbl[i].f);
         chk($sformatf("vec%0d code", i), fault_code, tbl[i].code);
`ifdef TRA_MON_FORCE_RED_EN
         chk($sformatf("vec%0d force_red", i), force_red, tbl[i].f);
`endif
      end
      chk("reset phase ns", ns_phase_cnt, 0);

      // legal alternating cycle: phase counters follow every red->green
      step(0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      exp_ns = 0; exp_ew = 0; pn = 2'b00; pe = 2'b00;
      for (int t = 0; t < 150; t++) begin
         nl = cycle_light(t);
         el = cycle_light(t + 13);
         if (pn == 2'b00 && nl == 2'b10) exp_ns++;
         if (pe == 2'b00 && el == 2'b10) exp_ew++;
         pn = nl; pe = el;
         step(1, 0, nl, (nl == 2'b10) ? 2'b10 : 2'b00, el, (el == 2'b10) ? 2'b10 : 2'b00);
         if (fault !== 1'b0) chk($sformatf("legal t%0d fault", t), fault, 0);
      end
      chk("legal fault", fault, 0);
      chk("legal code", fault_code, 0);
      chk("legal ns phases", ns_phase_cnt, exp_ns);
      chk("legal ew phases", ew_phase_cnt, exp_ew);
      chk("legal ns phases=6", exp_ns, 6);

      // short yellow
      step(0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 2, 0, 0, 0);
      step(1, 0, 2, 0, 0, 0);
      step(1, 0, 1, 0, 0, 0);
      step(1, 0, 1, 0, 0, 0);
      chk("yel2 before red", fault, 0);
      step(1, 0, 0, 0, 0, 0);
      chk("yel2 fault", fault, 1);
      chk("yel2 code", fault_code, 5);
      // minimum yellow is accepted
      step(0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 2, 0, 0, 0);
      step(1, 0, 1, 0, 0, 0);
      step(1, 0, 1, 0, 0, 0);
      step(1, 0, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      chk("yel3 fault", fault, 0);
      chk("yel3 code", fault_code, 0);

      // stuck light: both heads change on the same edge, then hold
      step(0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 2, 0, 0, 0);
      step(1, 0, 1, 0, 0, 0);
      step(1, 0, 1, 0, 0, 0);
      step(1, 0, 1, 0, 0, 0);
      step(1, 0, 0, 0, 2, 0);
      for (int k = 2; k < MAXH; k++) step(1, 0, 0, 0, 2, 0);
      chk("hold 19 fault", fault, 0);
      step(1, 0, 0, 0, 2, 0);
      chk("hold 20 fault", fault, 1);
      chk("hold 20 code", fault_code, 6);
      step(1, 0, 0, 0, 0, 0);
      chk("hold ignore code", fault_code, 6);

      // randomized run against the model
      step(0, 0, 0, 0, 0, 0);
      nc = 2'b00; ec = 2'b00;
      for (int i = 0; i < 3000; i++) begin
         logic r, c;
         r  = ($urandom_range(0, 399) != 0);
         c  = (m_st == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 149) == 0);
         nc = rnd_car(nc, ec);
         ec = rnd_car(ec, nc);
         step(r, c, nc, rnd_hmn(nc), ec, rnd_hmn(ec));
         chk($sformatf("rnd%0d fault", i), fault, (m_st == 2) ? 1 : 0);
         chk($sformatf("rnd%0d code", i), fault_code, m_code);
         chk($sformatf("rnd%0d ns_cnt", i), ns_phase_cnt, m_cnt_ns);
         chk($sformatf("rnd%0d ew_cnt", i), ew_phase_cnt, m_cnt_ew);
`ifdef TRA_MON_FORCE_RED_EN
         chk($sformatf("rnd%0d force_red", i), force_red, (m_st == 2) ? 1 : 0);
`endif
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
